pwm_multi: RTL and testbench
============================

# pwm_multi

Multi-channel PWM generator with a shared period counter and per-channel duty and polarity. Generalises the single-channel percent-duty PWM: period and duty are absolute counts of CNT_W bits, and all settings are double-buffered and applied glitch-free only at period boundaries. It sits between the register/control logic and the output pins (motor, LED, backlight drives) in the sclk domain.

## Interface
- NUM_CH, 4: number of PWM channels (1..32).
- CNT_W, 16: width of the period counter, period and each duty value (2..32).

- sclk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  run counter; low = idle.
- period  in  CNT_W  counter period P in sclk cycles; 0 = channel outputs held inactive.
- duty  in  NUM_CH*CNT_W  packed duty counts; channel k uses bits [k*CNT_W +: CNT_W].
- polarity  in  NUM_CH  1 = invert channel output.
- load  in  1  one-cycle strobe; captures period/duty/polarity into shadow registers.
- pwm_out  out  NUM_CH  registered PWM outputs.
- cyc_start  out  1  registered one-cycle pulse at each counter return to 0.
- pending  out  1  shadow holds values not yet applied.

## Operation
- Three register sets: shadow (written by load), active (drives compare), counter cnt.
- load=1: shadow <= inputs, pending <= 1. The inputs are ignored on all other cycles.
- Transfer (active <= shadow, pending <= 0) happens when pending=1 and either:
  - idle: enable=0 or active period=0; or
  - boundary: the next cnt value is 0.
- Load and transfer in the same cycle: the transfer uses the pre-load shadow contents. The new values stay pending until the next boundary. If pending was 0, nothing transfers that cycle.
- Edge-aligned counting (default): cnt runs 0,1,…,P-1,0,… For P=1, cnt stays at 0.
- Raw channel level = (cnt < duty_k), compared unsigned. duty=0 gives 0%; duty>=P gives 100%.
- pwm_out[k] <= raw_k ^ polarity_k.
- Idle (enable=0 or active P=0):
  - cnt <= 0.
  - pwm_out[k] <= polarity_k (inactive level).
  - cyc_start <= 0.
- Duty and polarity change only at transfers. Period never changes mid-cycle, so cnt never exceeds P-1.
- Reset: cnt, all shadow and active registers, pending, pwm_out and cyc_start all go to 0.

## Timing
- pwm_out and cyc_start are registered from the current cnt and the active set. They lag cnt by 1 cycle.
- enable rising: the first cycle with enable=1 evaluates cnt=0. pwm_out and cyc_start reflect it on the next edge.
- Latency from load to a new output setting:
  - idle: applied 1 cycle after the load cycle; visible on pwm_out 1 cycle later.
  - running: applied at the first boundary after the load cycle.
- enable falling mid-period: cnt <= 0 and outputs go inactive on the next edge. Pending values apply while idle.
- rst mid-period overrides everything. Outputs are 0 on the following edge, even for channels where polarity=1.

## Configuration
- PWM_CENTER_EN defined: center-aligned counting.
  - cnt goes up 0..P-1, then down P-2..1, then back to 0. Period is 2P-2 cycles for P>=2; P=1 keeps cnt=0.
  - Compare rule, boundary rule ("next cnt is 0") and cyc_start are unchanged. Pulses are symmetric about cnt=P-1.
- PWM_CENTER_EN undefined: edge-aligned only; no up/down direction register is built.

## Test plan
- Reset, then load P=10, duty0=3, duty1=0, duty2=10, duty3=12, polarity=0, enable=1 -> ch0 repeats 3 high / 7 low; ch1 constant 0; ch2 and ch3 constant 1; cyc_start pulses every 10 cycles.
- Running at P=10: load duty0=7 while cnt=4 -> current period keeps 3 high; the next period starts with 7 high; pending clears at the boundary.
- Load on the exact boundary cycle (cnt=9) with pending=0 -> no change for that period; the new value applies at the following boundary.
- polarity0=1, duty0=3, then enable=0 -> pwm_out[0]=1 while idle. After re-enable, pattern is 3 low / 7 high, and the first cyc_start comes 1 cycle after enable.
- P=1 with duty=1, then load P=0 -> output constant 1, then inactive level after the transfer. Assert rst mid-period -> all outputs and pending are 0 on the next edge.
- With PWM_CENTER_EN, P=5, duty=2 -> cnt sequence 0,1,2,3,4,3,2,1; high on cnt 0,1 only; period 8; cyc_start every 8 cycles.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with one shared period counter and per-channel
// duty/polarity. period/duty/polarity are captured into a shadow set on
// `load` and moved into the active set only while idle or when the counter is
// about to return to 0, so a running period is never disturbed.
//
// Optional build macro: PWM_CENTER_EN selects center-aligned (up/down)
// counting. Without it the counter is edge-aligned and there is no direction
// register.
//
// Ports:
//   sclk, rst   clock, synchronous active-high reset
//   enable      run counter; low = idle (outputs at inactive level)
//   period      counter period P; 0 holds outputs inactive
//   duty        packed duty counts, channel k at [k*CNT_W +: CNT_W]
//   polarity    per-channel output inversion
//   load        strobe capturing period/duty/polarity into the shadow set
//   pwm_out     registered PWM outputs
//   cyc_start   registered pulse each time the counter returns to 0
//   pending     shadow holds values not yet applied

// Per-channel lane: shadow/active duty+polarity and the output flop.
module pwm_multi_ch #(
  parameter int CNT_W = 16
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             load,
  input  logic             xfer,
  input  logic             idle,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             pol_in,
  output logic             pwm
);
  logic [CNT_W-1:0] sh_duty, act_duty;
  logic             sh_pol, act_pol;

  always_ff @(posedge sclk) begin
    if (rst) begin
      sh_duty  <= '0;
      sh_pol   <= 1'b0;
      act_duty <= '0;
      act_pol  <= 1'b0;
      pwm      <= 1'b0;
    end else begin
      if (load) begin
        sh_duty <= duty_in;
        sh_pol  <= pol_in;
      end
      // Same-cycle load+xfer: nonblocking update hands over the old shadow.
      if (xfer) begin
        act_duty <= sh_duty;
        act_pol  <= sh_pol;
      end
      pwm <= idle ? act_pol : ((cnt < act_duty) ^ act_pol);
    end
  end
endmodule

module pwm_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [CNT_W-1:0]        period,
  input  logic [NUM_CH*CNT_W-1:0] duty,
  input  logic [NUM_CH-1:0]       polarity,
  input  logic                    load,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    cyc_start,
  output logic                    pending
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] sh_period, act_period;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             idle, xfer;

  assign idle = !enable || (act_period == '0);
  // Idle forces cnt_nxt to 0, so this covers both the idle and boundary cases.
  assign xfer = pending && (cnt_nxt == '0);

`ifdef PWM_CENTER_EN
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  logic dir, dir_nxt;  // 0 = counting up, 1 = counting down

  always_comb begin
    cnt_nxt = '0;
    dir_nxt = 1'b0;
    if (!idle) begin
      if (!dir) begin
        if (cnt == act_period - ONE) begin
          // P<=2 has no down leg: wrap straight back to 0.
          if (act_period > TWO) begin
            cnt_nxt = cnt - ONE;
            dir_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end else begin
        cnt_nxt = cnt - ONE;
        dir_nxt = (cnt != ONE);
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) dir <= 1'b0;
    else     dir <= dir_nxt;
  end
`else
  always_comb begin
    cnt_nxt = '0;
    if (!idle && (cnt != act_period - ONE))
      cnt_nxt = cnt + ONE;
  end
`endif

  always_ff @(posedge sclk) begin
    if (rst) begin
      cnt        <= '0;
      sh_period  <= '0;
      act_period <= '0;
      pending    <= 1'b0;
      cyc_start  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      cyc_start <= !idle && (cnt == '0);
      if (load) begin
        sh_period <= period;
        pending   <= 1'b1;
      end else if (xfer) begin
        pending   <= 1'b0;
      end
      if (xfer) act_period <= sh_period;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pwm_multi_ch #(.CNT_W(CNT_W)) u_ch (
      .sclk    (sclk),
      .rst     (rst),
      .load    (load),
      .xfer    (xfer),
      .idle    (idle),
      .cnt     (cnt),
      .duty_in (duty[k*CNT_W +: CNT_W]),
      .pol_in  (polarity[k]),
      .pwm     (pwm_out[k])
    );
  end
endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (NUM_CH=4, CNT_W=16). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_pwm_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic                    sclk = 1'b0;
  logic                    rst = 1'b1;
  logic                    enable = 1'b0;
  logic [CNT_W-1:0]        period = '0;
  logic [NUM_CH*CNT_W-1:0] duty = '0;
  logic [NUM_CH-1:0]       polarity = '0;
  logic                    load = 1'b0;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    cyc_start;
  logic                    pending;

  int n_chk  = 0;
  int n_fail = 0;
  int ph     = 0;  // counter value the next edge evaluates (P=10 runs)

  pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .enable    (enable),
    .period    (period),
    .duty      (duty),
    .polarity  (polarity),
    .load      (load),
    .pwm_out   (pwm_out),
    .cyc_start (cyc_start),
    .pending   (pending)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // One P=10 cycle: ch0 duty d0 / polarity p0; ch1..3 fixed at 0,1,1.
  task automatic step(input int d0, input bit p0);
    logic [3:0] e;
    tick();
    e = {3'b110, ((ph < d0) ? 1'b1 : 1'b0) ^ p0};
    check($sformatf("pwm ph%0d", ph), 32'(pwm_out), 32'(e));
    check($sformatf("cyc ph%0d", ph), 32'(cyc_start), (ph == 0) ? 32'd1 : 32'd0);
    ph = (ph + 1) % 10;
  endtask

  task automatic steps(input int n, input int d0, input bit p0);
    for (int i = 0; i < n; i++) step(d0, p0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst pwm", 32'(pwm_out), 32'd0);
    check("rst cyc", 32'(cyc_start), 32'd0);
    check("rst pending", 32'(pending), 32'd0);
    rst = 1'b0;

`ifdef PWM_CENTER_EN
    begin
      int cseq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
      period = 16'd5; duty = {4{16'd2}}; polarity = '0; enable = 1'b1; load = 1'b1;
      tick(); load = 1'b0;
      tick();
      check("ctr xfer pending", 32'(pending), 32'd0);
      for (int i = 0; i < 16; i++) begin
        tick();
        check($sformatf("ctr pwm %0d", i), 32'(pwm_out), (cseq[i%8] < 2) ? 32'hF : 32'h0);
        check($sformatf("ctr cyc %0d", i), 32'(cyc_start), (i % 8 == 0) ? 32'd1 : 32'd0);
      end
    end
`else
    // P=10, duties 3/0/10/12, start from idle
    period = 16'd10; duty = {16'd12, 16'd10, 16'd0, 16'd3}; polarity = '0;
    enable = 1'b1; load = 1'b1;
    tick(); load = 1'b0;
    check("load pending", 32'(pending), 32'd1);
    check("load idle pwm", 32'(pwm_out), 32'd0);
    tick();
    check("idle xfer pending", 32'(pending), 32'd0);
    check("idle xfer pwm", 32'(pwm_out), 32'd0);
    ph = 0;
    steps(20, 3, 1'b0);

    // Load duty0=7 while cnt=4: current period keeps 3
    steps(4, 3, 1'b0);
    duty = {16'd12, 16'd10, 16'd0, 16'd7}; load = 1'b1;
    step(3, 1'b0); load = 1'b0;
    check("mid pending set", 32'(pending), 32'd1);
    steps(4, 3, 1'b0);
    check("mid pending held", 32'(pending), 32'd1);
    step(3, 1'b0);
    check("mid pending clr", 32'(pending), 32'd0);
    steps(10, 7, 1'b0);

    // Load on the boundary cycle (cnt=9) with pending=0
    steps(9, 7, 1'b0);
    duty = {16'd12, 16'd10, 16'd0, 16'd5}; load = 1'b1;
    step(7, 1'b0); load = 1'b0;
    check("bnd pending set", 32'(pending), 32'd1);
    steps(10, 7, 1'b0);
    check("bnd pending clr", 32'(pending), 32'd0);
    steps(10, 5, 1'b0);

    // Polarity0=1, duty0=3, then idle and re-enable
    duty = {16'd12, 16'd10, 16'd0, 16'd3}; polarity = 4'b0001; load = 1'b1;
    step(5, 1'b0); load = 1'b0;
    steps(9, 5, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle pol pwm", 32'(pwm_out), 32'h1);
      check("idle cyc", 32'(cyc_start), 32'd0);
    end
    enable = 1'b1; ph = 0;
    steps(20, 3, 1'b1);

    // P=1 duty=1 -> constant 1, then P=0 -> inactive
    period = 16'd1; duty = {4{16'd1}}; polarity = '0; load = 1'b1;
    step(3, 1'b1); load = 1'b0;
    steps(9, 3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("p1 pwm", 32'(pwm_out), 32'hF);
      check("p1 cyc", 32'(cyc_start), 32'd1);
    end
    period = 16'd0; load = 1'b1;
    tick(); load = 1'b0;
    check("p0 load pwm", 32'(pwm_out), 32'hF);
    check("p0 load pending", 32'(pending), 32'd1);
    tick();
    check("p0 xfer pwm", 32'(pwm_out), 32'hF);
    check("p0 xfer pending", 32'(pending), 32'd0);
    tick();
    check("p0 idle pwm", 32'(pwm_out), 32'h0);
    check("p0 idle cyc", 32'(cyc_start), 32'd0);

    // Mixed polarity run, then reset mid-period with a load pending
    period = 16'd10; duty = {4{16'd3}}; polarity = 4'b1010; load = 1'b1;
    tick(); load = 1'b0;
    check("rp load pwm", 32'(pwm_out), 32'h0);
    tick();
    check("rp xfer pwm", 32'(pwm_out), 32'h0);
    tick();
    check("rp cnt0 pwm", 32'(pwm_out), 32'h5);
    check("rp cnt0 cyc", 32'(cyc_start), 32'd1);
    tick(); tick();
    check("rp cnt2 pwm", 32'(pwm_out), 32'h5);
    tick();
    check("rp cnt3 pwm", 32'(pwm_out), 32'hA);
    duty = {4{16'd5}}; load = 1'b1;
    tick(); load = 1'b0;
    check("rp cnt4 pwm", 32'(pwm_out), 32'hA);
    check("rp pending", 32'(pending), 32'd1);
    rst = 1'b1;
    tick();
    check("mid rst pwm", 32'(pwm_out), 32'h0);
    check("mid rst pending", 32'(pending), 32'd0);
    check("mid rst cyc", 32'(cyc_start), 32'd0);
    rst = 1'b0;
    tick();
    check("post rst pwm", 32'(pwm_out), 32'h0);
    check("post rst cyc", 32'(cyc_start), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
